// File: rtl/rv_pipe_pkg.sv
// Shared constants and helpers for the RV32I pipeline stages.
// Used by if_stage and if_id_reg.
package rv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  // Instructions are word aligned, so redirect targets drop their two low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > stall > load priority.
// A flushed register holds a bubble: NOP word, zero PCs, valid cleared.
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d    = NOP;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (!stall_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Define IF_MISALIGN_CHK_EN to add the sticky fetch_misaligned flag and extra bubble.
module if_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_plus4_f;
  logic            ifid_flush;

  assign pc_plus4_f = pc_f_q + PC_INCR;
  assign imem_addr  = pc_f_q;

  // A redirect beats stall_f: the stalled instruction in D is squashed anyway.
  always_comb begin
    pc_f_d = pc_plus4_f;
    if (pc_src_e) begin
      pc_f_d = align_word(pc_target_e);
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  logic misaligned_q, misaligned_d;
  logic extra_bubble_q, extra_bubble_d;
  logic misaligned_redirect;

  assign misaligned_redirect = pc_src_e && (pc_target_e[1:0] != 2'b00);

  // The flag is sticky until reset; the extra bubble discards the aligned target once.
  always_comb begin
    misaligned_d   = misaligned_q | misaligned_redirect;
    extra_bubble_d = misaligned_redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q   <= 1'b0;
      extra_bubble_q <= 1'b0;
    end else begin
      misaligned_q   <= misaligned_d;
      extra_bubble_q <= extra_bubble_d;
    end
  end

  assign fetch_misaligned = misaligned_q;
  assign ifid_flush       = flush_d | pc_src_e | extra_bubble_q;
`else
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^pc_target_e[1:0];
  assign ifid_flush         = flush_d | pc_src_e;
`endif

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (ifid_flush),
    .stall_i    (stall_d),
    .instr_i    (imem_rdata),
    .pc_i       (pc_f_q),
    .pc_plus4_i (pc_plus4_f),
    .instr_o    (instr_d),
    .pc_o       (pc_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage, with a second instance
// reset near the top of the address space to exercise PC wrap-around.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] instr_d2;
  logic [31:0] pc_d2;
  logic [31:0] pc_plus4_d2;
  logic        valid_d2;

`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misaligned;
  logic        fetch_misaligned2;
`endif

  int errors = 0;
  int checks = 0;

  // Instruction memory contents: each word is its address XOR 0xDEAD0000.
  assign imem_rdata  = imem_addr ^ 32'hDEAD_0000;
  assign imem_rdata2 = imem_addr2 ^ 32'hDEAD_0000;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  if_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dutWrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (1'b0),
    .stall_d     (1'b0),
    .flush_d     (1'b0),
    .pc_src_e    (1'b0),
    .pc_target_e (32'h0),
    .imem_addr   (imem_addr2),
    .imem_rdata  (imem_rdata2),
    .instr_d     (instr_d2),
    .pc_d        (pc_d2),
    .pc_plus4_d  (pc_plus4_d2),
    .valid_d     (valid_d2)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misaligned (fetch_misaligned2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One active edge, then settle at the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic sf, input logic sd, input logic fd,
                               input logic src, input logic [31:0] tgt);
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fd;
    pc_src_e    = src;
    pc_target_e = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'h0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("reset_addr", imem_addr, 32'h0);
    checkOutput("reset_instr", instr_d, 32'h0000_0013);
    checkOutput("reset_pc_d", pc_d, 32'h0);
    checkOutput("reset_pc4_d", pc_plus4_d, 32'h0);
    checkOutput("reset_valid", {31'b0, valid_d}, 32'h0);
    checkOutput("wrap_reset_addr", imem_addr2, 32'hFFFF_FFF8);
`ifdef IF_MISALIGN_CHK_EN
    checkOutput("reset_misaligned", {31'b0, fetch_misaligned}, 32'h0);
`endif

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run1_addr", imem_addr, 32'h4);
    checkOutput("run1_instr", instr_d, 32'hDEAD_0000);
    checkOutput("run1_valid", {31'b0, valid_d}, 32'h1);
    checkOutput("run1_pc4", pc_plus4_d, 32'h4);
    checkOutput("wrap1_addr", imem_addr2, 32'hFFFF_FFFC);
    checkOutput("wrap1_pc_d", pc_d2, 32'hFFFF_FFF8);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run2_addr", imem_addr, 32'h8);
    checkOutput("run2_instr", instr_d, 32'hDEAD_0004);
    checkOutput("wrap2_addr", imem_addr2, 32'h0);
    checkOutput("wrap2_pc_d", pc_d2, 32'hFFFF_FFFC);
    checkOutput("wrap2_pc4", pc_plus4_d2, 32'h0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_addr", imem_addr, 32'h8);
      checkOutput("stall_instr", instr_d, 32'hDEAD_0004);
      checkOutput("stall_pc_d", pc_d, 32'h4);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_addr", imem_addr, 32'hC);
    checkOutput("resume_instr", instr_d, 32'hDEAD_0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("resume2_addr", imem_addr, 32'h10);
    checkOutput("resume2_instr", instr_d, 32'hDEAD_000C);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkOutput("redir_instr", instr_d, 32'h0000_0013);
    checkOutput("redir_valid", {31'b0, valid_d}, 32'h0);
    checkOutput("redir_pc_d", pc_d, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("target_instr", instr_d, 32'hDEAD_0100);
    checkOutput("target_pc_d", pc_d, 32'h100);
    checkOutput("target_valid", {31'b0, valid_d}, 32'h1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flushstall_addr", imem_addr, 32'h108);
    checkOutput("flushstall_instr", instr_d, 32'h0000_0013);
    checkOutput("flushstall_valid", {31'b0, valid_d}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("postflush_instr", instr_d, 32'hDEAD_0108);
    checkOutput("postflush_pc4", pc_plus4_d, 32'h10C);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
    checkOutput("mis_addr", imem_addr, 32'h100);
    checkOutput("mis_instr", instr_d, 32'h0000_0013);
`ifdef IF_MISALIGN_CHK_EN
    checkOutput("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mis2_addr", imem_addr, 32'h104);
`ifdef IF_MISALIGN_CHK_EN
    checkOutput("mis2_instr", instr_d, 32'h0000_0013);
    checkOutput("mis2_valid", {31'b0, valid_d}, 32'h0);
    checkOutput("mis2_flag", {31'b0, fetch_misaligned}, 32'h1);
`else
    checkOutput("mis2_instr", instr_d, 32'hDEAD_0100);
    checkOutput("mis2_valid", {31'b0, valid_d}, 32'h1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("mis3_instr", instr_d, 32'hDEAD_0104);
`ifdef IF_MISALIGN_CHK_EN
    checkOutput("mis3_flag", {31'b0, fetch_misaligned}, 32'h1);
`endif

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("dup_addr", imem_addr, 32'h108);
      checkOutput("dup_instr", instr_d, 32'hDEAD_0108);
      checkOutput("dup_pc_d", pc_d, 32'h108);
    end

    stall_f = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_addr", imem_addr, 32'h0);
    checkOutput("midrst_instr", instr_d, 32'h0000_0013);
    checkOutput("midrst_valid", {31'b0, valid_d}, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    checkOutput("midrst_flag", {31'b0, fetch_misaligned}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rerun_addr", imem_addr, 32'h4);
    checkOutput("rerun_instr", instr_d, 32'hDEAD_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core: PC register, next-PC selection, instruction-memory address, and IF/ID pipeline register.
- Its instr_d output is the 32-bit instruction word consumed by the decode-stage control path and register file.
- Obeys stall and flush requests from the hazard unit and redirect requests from the execute stage (branch, jal, jalr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush and reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold PC.
- stall_d  in  1  hold IF/ID register.
- flush_d  in  1  bubble IF/ID register.
- pc_src_e  in  1  redirect request from EX (taken branch / jump).
- pc_target_e  in  32  redirect target from EX.
- imem_addr  out  32  instruction-memory address (combinational, equals pc_f).
- imem_rdata  in  32  instruction word, asynchronous-read memory, valid in the same cycle.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real fetched instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0): pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
- Release: the first fetch occurs at RESET_PC on the first rising edge with rst_n=1.
- pc_plus4_f = pc_f + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0, no flag).
- PC update per edge, in priority order:
  - pc_src_e=1: pc_f <= {pc_target_e[31:2],2'b00}.
  - else stall_f=1: hold.
  - else: pc_f <= pc_plus4_f.
  - Redirect overrides stall_f, because the stalled D-stage instruction is squashed by the redirect.
- IF/ID update per edge, in priority order:
  - flush_d=1 or pc_src_e=1: bubble (instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0). pc_src_e flushes internally; the hazard unit need not also assert flush_d.
  - else stall_d=1: hold all four fields.
  - else: instr_d<=imem_rdata, pc_d<=pc_f, pc_plus4_d<=pc_plus4_f, valid_d<=1.
- Latency: the word at address A appears on instr_d exactly one cycle after pc_f==A, absent stall/flush.
- Redirect penalty: the instruction fetched in the redirect cycle is discarded. The target instruction reaches instr_d two edges after pc_src_e is sampled.
- stall_f=1 with stall_d=0 is legal. The same word is re-captured each cycle, so IF/ID sees duplicates; the hazard unit is responsible for not generating this case.
- Simultaneous flush_d and stall_d: flush wins.
- Reset asserted mid-operation: all state returns to reset values immediately (async). No partial fetch survives.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - pc_src_e=1 with pc_target_e[1:0]!=0 sets sticky output fetch_misaligned (1 bit, reset 0, cleared only by rst_n).
  - The PC still loads the aligned target.
  - The IF/ID bubble is forced on the following edge as well, so the instruction at the aligned target is discarded once.
- Undefined: low bits are silently cleared, there is no fetch_misaligned port, and the penalty is the normal redirect penalty.

Decomposition:
- Shared package rv_pipe_pkg: XLEN=32, NOP_INSTR constant, RESET_PC default, PC_INCR=4.
- One natural sub-module: if_id_reg, holding the IF/ID fields with flush>stall>load priority.
- PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then release with imem returning addr-dependent words: imem_addr sequence 0,4,8,C; instr_d lags one cycle; valid_d goes 0→1 after the first edge.
- stall_f=stall_d=1 for 3 cycles at pc_f=8: pc_f stays 8 and instr_d holds word@4; on release, the sequence resumes at C with no loss or duplication.
- pc_src_e=1, pc_target_e=0x100 while pc_f=0x10: next pc_f=0x100; instr_d=NOP, valid_d=0 for one cycle; the following cycle instr_d=word@0x100, pc_d=0x100.
- flush_d=1 and stall_d=1 together: IF/ID becomes a bubble (NOP, valid_d=0); stall_f=0 so the PC advances.
- RESET_PC=0xFFFF_FFF8, free-run: pc_f goes FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_d for FFFF_FFFC is 0.
- With IF_MISALIGN_CHK_EN defined, pc_target_e=0x102: pc_f=0x100, fetch_misaligned=1 and sticky, two bubble cycles. Without the macro, one bubble and no flag.
